ddr3_req_scheduler: RTL and testbench
=====================================

DDR3_REQ_SCHEDULER -- requirements
Module: ddr3_req_scheduler

Interface
REQ-001 Parameter REFRESH_COUNT, default 615, clk cycles per tREFI (7.8125 us at 78.75 MHz).
REQ-002 Parameter URGENT_DEBT, default 4, owed-refresh level at which refresh pre-empts user requests.
REQ-003 Parameter MAX_DEBT, default 8, saturation limit of owed refreshes (JEDEC postpone limit).
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  controller pclk domain; all logic rising-edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 req_rd  in  1  user read request, held until accepted.
REQ-008 req_wr  in  1  user write request, held until accepted.
REQ-009 req_addr  in  26  user word address.
REQ-010 req_din  in  16  user write data.
REQ-011 req_ready  out  1  request accepted this cycle when high with req_rd or req_wr.
REQ-012 resp_valid  out  1  one-cycle pulse, read data valid.
REQ-013 resp_dout  out  16  read data, held until next resp_valid.
REQ-014 ctl_rd, ctl_wr, ctl_refresh  out  1 each  one-cycle command pulses to controller.
REQ-015 ctl_addr  out  26; ctl_din  out  16  command operands, stable from pulse until command completes.
REQ-016 ctl_busy  in  1; ctl_data_ready  in  1; ctl_dout  in  16  controller status and read data.
REQ-017 refresh_debt  out  4  current owed refreshes.
REQ-018 debt_overflow  out  1  sticky: a tREFI tick occurred with debt already at MAX_DEBT.

Function
REQ-019 Timer counts 0..REFRESH_COUNT-1 and wraps; wrap cycle is a tick.
REQ-020 Tick increments refresh_debt, saturating at MAX_DEBT; tick at MAX_DEBT sets debt_overflow instead.
REQ-021 Refresh completion decrements refresh_debt; tick and completion in the same cycle leave it unchanged.
REQ-022 FSM states: IDLE, CMD, SETTLE, WAIT.
REQ-023 IDLE select priority: (1) refresh if debt >= URGENT_DEBT; (2) user write; (3) user read; (4) refresh if debt > 0 and no user request.
REQ-024 req_rd and req_wr both high: write is serviced; read stays pending, not dropped.
REQ-025 req_ready is combinational, high only in IDLE when the selection is a user request; low in all other states and during reset.
REQ-026 Acceptance latches address/data/type; next cycle is CMD.
REQ-027 CMD: exactly one of ctl_rd/ctl_wr/ctl_refresh high for one cycle; go to SETTLE.
REQ-028 SETTLE: one cycle, ignores ctl_busy (controller raises busy one cycle late); go to WAIT.
REQ-029 WAIT (write/refresh): leave to IDLE on first cycle with ctl_busy low; refresh completion counted on that cycle.
REQ-030 WAIT (read): capture ctl_dout on ctl_data_ready, pulse resp_valid next cycle; leave to IDLE only after data captured and ctl_busy low.
REQ-031 ctl_data_ready outside a read WAIT is ignored; no resp_valid.
REQ-032 Minimum command spacing: 3 cycles (CMD, SETTLE, >=1 WAIT); back-to-back accepts impossible.
REQ-033 Timer and debt run in all states; ctl_busy never stalls the timer.

Reset
REQ-034 On reset: FSM IDLE, timer 0, refresh_debt 0, debt_overflow 0, all ctl_* pulses 0, ctl_addr/ctl_din 0, resp_valid 0, resp_dout 0.
REQ-035 Reset mid-command: outputs return to reset values immediately; in-flight request discarded, no resp_valid; requester must re-issue.
REQ-036 First cycle after reset release with a pending request: req_ready high (debt 0).

Verification
REQ-037 Write 0x1234 @0x0 with ctl_busy high 5 cycles after SETTLE -> single ctl_wr pulse, ctl_addr 0x0, ctl_din 0x1234, req_ready low until busy drops.
REQ-038 Read @0x2, controller returns 0xABCD with data_ready in WAIT -> resp_valid one cycle later, resp_dout 0xABCD, exactly one ctl_rd.
REQ-039 No traffic for 2*REFRESH_COUNT cycles -> two ctl_refresh pulses, each after a tick; refresh_debt returns to 0.
REQ-040 Continuous user writes, REFRESH_COUNT=16 -> debt climbs to 4, then a ctl_refresh precedes the next accepted write; debt never exceeds 4 in steady state.
REQ-041 ctl_busy stuck high for 9*REFRESH_COUNT cycles -> debt saturates at 8, debt_overflow 1 and sticky after busy releases.
REQ-042 Assert reset during read WAIT -> all outputs at reset values same cycle, no resp_valid after release, debt 0.

Source files
------------

// File: rtl/ddr3_req_scheduler.sv
// ddr3_req_scheduler: arbitrates user read/write requests against periodic DDR3 refresh.
// Ports:
//   clk, reset                        clock, async active-high reset
//   req_rd/req_wr/req_addr/req_din    held user request; req_ready marks acceptance
//   resp_valid/resp_dout              read data pulse and held read data
//   ctl_rd/ctl_wr/ctl_refresh         one-cycle command pulses to the controller
//   ctl_addr/ctl_din                  command operands, stable until completion
//   ctl_busy/ctl_data_ready/ctl_dout  controller status and read data
//   refresh_debt/debt_overflow        owed refreshes and sticky overflow flag
module ddr3_req_scheduler #(
    parameter int REFRESH_COUNT = 615,
    parameter int URGENT_DEBT   = 4,
    parameter int MAX_DEBT      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [25:0] req_addr,
    input  logic [15:0] req_din,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [15:0] resp_dout,
    output logic        ctl_rd,
    output logic        ctl_wr,
    output logic        ctl_refresh,
    output logic [25:0] ctl_addr,
    output logic [15:0] ctl_din,
    input  logic        ctl_busy,
    input  logic        ctl_data_ready,
    input  logic [15:0] ctl_dout,
    output logic [3:0]  refresh_debt,
    output logic        debt_overflow
);
    localparam int TW = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
    typedef enum logic [1:0] {IDLE, CMD, SETTLE, WAIT} state_t;
    typedef enum logic [1:0] {OP_RD, OP_WR, OP_REF} op_t;
    state_t        state;
    op_t           op;
    logic [TW-1:0] timer;
    logic          tick, refresh_done, urgent, user_req, sel_ref, got_data;
    assign tick         = timer == TW'(REFRESH_COUNT - 1);
    assign refresh_done = state == WAIT && op == OP_REF && !ctl_busy;
    assign urgent       = refresh_debt >= 4'(URGENT_DEBT);
    assign user_req     = req_rd | req_wr;
    assign sel_ref      = urgent || (!user_req && refresh_debt != 4'd0);
    assign req_ready    = !reset && state == IDLE && user_req && !urgent;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer         <= '0;
            refresh_debt  <= 4'd0;
            debt_overflow <= 1'b0;
        end else begin
            timer <= tick ? '0 : timer + 1'b1;
            if (tick && refresh_debt == 4'(MAX_DEBT))
                debt_overflow <= 1'b1;
            // a tick and a completion in the same cycle cancel out
            if (tick && !refresh_done && refresh_debt != 4'(MAX_DEBT))
                refresh_debt <= refresh_debt + 4'd1;
            else if (refresh_done && !tick && refresh_debt != 4'd0)
                refresh_debt <= refresh_debt - 4'd1;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            op          <= OP_RD;
            got_data    <= 1'b0;
            ctl_rd      <= 1'b0;
            ctl_wr      <= 1'b0;
            ctl_refresh <= 1'b0;
            ctl_addr    <= '0;
            ctl_din     <= '0;
            resp_valid  <= 1'b0;
            resp_dout   <= '0;
        end else begin
            ctl_rd      <= 1'b0;
            ctl_wr      <= 1'b0;
            ctl_refresh <= 1'b0;
            resp_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_ref) begin
                        op          <= OP_REF;
                        ctl_refresh <= 1'b1;
                        state       <= CMD;
                    end else if (user_req) begin
                        // write wins when both are requested; the read stays pending
                        op       <= req_wr ? OP_WR : OP_RD;
                        ctl_wr   <= req_wr;
                        ctl_rd   <= !req_wr;
                        ctl_addr <= req_addr;
                        ctl_din  <= req_din;
                        state    <= CMD;
                    end
                end
                CMD: begin
                    got_data <= 1'b0;
                    state    <= SETTLE;
                end
                // controller raises busy one cycle late, so busy is not trusted here
                SETTLE: state <= WAIT;
                WAIT: begin
                    if (op == OP_RD) begin
                        if (ctl_data_ready && !got_data) begin
                            resp_dout  <= ctl_dout;
                            resp_valid <= 1'b1;
                            got_data   <= 1'b1;
                        end
                        if (got_data && !ctl_busy)
                            state <= IDLE;
                    end else if (!ctl_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr3_req_scheduler.sv
// tb_ddr3_req_scheduler: randomized self-checking bench against a transaction-level scheduler model.
module tb_ddr3_req_scheduler;
    localparam int N = 16;
    localparam int U = 4;
    localparam int MAXD = 8;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_rd = 1'b0, req_wr = 1'b0;
    logic [25:0] req_addr = '0;
    logic [15:0] req_din = '0;
    logic        req_ready, resp_valid, ctl_rd, ctl_wr, ctl_refresh, debt_overflow;
    logic [15:0] resp_dout, ctl_din;
    logic [25:0] ctl_addr;
    logic        ctl_busy = 1'b0, ctl_data_ready = 1'b0;
    logic [15:0] ctl_dout = '0;
    logic [3:0]  refresh_debt;
    ddr3_req_scheduler #(.REFRESH_COUNT(N), .URGENT_DEBT(U), .MAX_DEBT(MAXD)) dut (
        .clk(clk), .reset(reset), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
        .req_din(req_din), .req_ready(req_ready), .resp_valid(resp_valid), .resp_dout(resp_dout),
        .ctl_rd(ctl_rd), .ctl_wr(ctl_wr), .ctl_refresh(ctl_refresh), .ctl_addr(ctl_addr),
        .ctl_din(ctl_din), .ctl_busy(ctl_busy), .ctl_data_ready(ctl_data_ready),
        .ctl_dout(ctl_dout), .refresh_debt(refresh_debt), .debt_overflow(debt_overflow)
    );
    always #5 clk = ~clk;
    int n_checks = 0, n_pass = 0;
    int p_req, wr_only, busy_min, busy_max, dd_min, dd_max, spur, stuck, force_dout;
    logic [15:0] dout_val;
    int k, busy_left, dr_at;
    bit pulse_prev, rd_prev, acc_prev;
    bit m_busy, m_got;
    int m_op, m_start, m_debt, cap_k;
    bit m_ovf;
    logic [25:0] m_addr;
    logic [15:0] m_din, cap_d;
    int cnt_rd, cnt_wr, cnt_ref, cnt_resp, max_debt;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k);
    endtask
    task automatic check_reset_outputs();
        check("rst_ready", req_ready, 0);
        check("rst_pulses", {ctl_rd, ctl_wr, ctl_refresh}, 0);
        check("rst_addr", ctl_addr, 0);
        check("rst_din", ctl_din, 0);
        check("rst_resp", {resp_valid, resp_dout}, 0);
        check("rst_debt", {debt_overflow, refresh_debt}, 0);
    endtask
    task automatic clear_counts();
        cnt_rd = 0; cnt_wr = 0; cnt_ref = 0; cnt_resp = 0; max_debt = 0;
    endtask
    task automatic do_reset(input bit keep_req);
        reset = 1'b1;
        ctl_busy = 1'b0; ctl_data_ready = 1'b0;
        if (!keep_req) begin
            req_rd = 1'b0; req_wr = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 check_reset_outputs();
        @(posedge clk);
        #1 reset = 1'b0;
        k = 0; busy_left = 0; dr_at = -10;
        pulse_prev = 0; rd_prev = 0; acc_prev = 0;
        m_busy = 0; m_got = 0; m_op = 0; m_start = -10; m_debt = 0; m_ovf = 0;
        cap_k = -10; cap_d = '0; m_addr = '0; m_din = '0;
        clear_counts();
    endtask
    task automatic step();
        bit user, sel_ref, done, tick, got_prev;
        logic [2:0] exp_pulse;
        int kind;
        @(negedge clk);
        if (acc_prev) begin
            if (req_wr) req_wr = 1'b0;
            else req_rd = 1'b0;
        end
        acc_prev = 0;
        if (!req_rd && !req_wr && $urandom_range(99) < p_req) begin
            kind = wr_only ? 1 : int'($urandom_range(3));
            req_rd = (kind == 0 || kind == 2);
            req_wr = (kind != 0);
            req_addr = 26'($urandom);
            req_din = 16'($urandom);
        end
        if (pulse_prev) busy_left = $urandom_range(busy_max, busy_min);
        if (rd_prev) dr_at = k - 1 + int'($urandom_range(dd_max, dd_min));
        ctl_busy = stuck != 0 || busy_left > 0;
        if (busy_left > 0) busy_left--;
        ctl_data_ready = (k == dr_at) || (spur != 0 && $urandom_range(7) == 0);
        ctl_dout = force_dout != 0 ? dout_val : 16'($urandom);
        #1;
        pulse_prev = ctl_rd | ctl_wr | ctl_refresh;
        rd_prev = ctl_rd;
        cnt_rd += int'(ctl_rd); cnt_wr += int'(ctl_wr);
        cnt_ref += int'(ctl_refresh); cnt_resp += int'(resp_valid);
        if (int'(refresh_debt) > max_debt) max_debt = int'(refresh_debt);
        user = req_rd | req_wr;
        check("req_ready", req_ready, !m_busy && user && m_debt < U);
        exp_pulse = (m_busy && k == m_start + 1) ? (m_op == 0 ? 3'b100 : m_op == 1 ? 3'b010 : 3'b001) : 3'b000;
        check("ctl_pulses", {ctl_rd, ctl_wr, ctl_refresh}, exp_pulse);
        if (m_busy && m_op != 2 && k > m_start) begin
            check("ctl_addr", ctl_addr, m_addr);
            check("ctl_din", ctl_din, m_din);
        end
        check("resp_valid", resp_valid, k == cap_k + 1);
        check("resp_dout", resp_dout, cap_d);
        check("refresh_debt", refresh_debt, m_debt);
        check("debt_overflow", debt_overflow, m_ovf);
        done = 0;
        if (!m_busy) begin
            sel_ref = m_debt >= U || (!user && m_debt > 0);
            if (sel_ref || user) begin
                m_busy = 1; m_start = k; m_got = 0;
                m_op = sel_ref ? 2 : req_wr ? 1 : 0;
                if (!sel_ref) begin
                    m_addr = req_addr; m_din = req_din; acc_prev = 1;
                end
            end
        end else if (k >= m_start + 3) begin
            if (m_op == 0) begin
                got_prev = m_got;
                if (ctl_data_ready && !m_got) begin
                    m_got = 1; cap_k = k; cap_d = ctl_dout;
                end
                if (got_prev && !ctl_busy) m_busy = 0;
            end else if (!ctl_busy) begin
                m_busy = 0;
                done = (m_op == 2);
            end
        end
        tick = (k % N) == N - 1;
        if (tick && m_debt == MAXD) m_ovf = 1;
        if (tick && !done && m_debt < MAXD) m_debt++;
        else if (done && !tick) m_debt--;
        k++;
    endtask
    task automatic set_knobs(input int pr, input int wo, input int bmin, input int bmax,
                             input int dmin, input int dmax, input int sp);
        p_req = pr; wr_only = wo; busy_min = bmin; busy_max = bmax;
        dd_min = dmin; dd_max = dmax; spur = sp; stuck = 0; force_dout = 0;
    endtask
    initial begin
        bit found;
        set_knobs(0, 0, 0, 0, 2, 2, 0);
        dout_val = '0;
        req_wr = 1'b1; req_addr = 26'h0; req_din = 16'h1234;
        set_knobs(0, 0, 6, 6, 2, 2, 0);
        do_reset(1);
        repeat (20) step();
        check("p1_wr_count", cnt_wr, 1);
        check("p1_ctl_addr", ctl_addr, 26'h0);
        check("p1_ctl_din", ctl_din, 16'h1234);
        req_rd = 1'b1; req_addr = 26'h2; req_din = 16'h0;
        set_knobs(0, 0, 0, 2, 3, 3, 0);
        force_dout = 1; dout_val = 16'hABCD;
        do_reset(1);
        repeat (20) step();
        check("p2_rd_count", cnt_rd, 1);
        check("p2_resp_count", cnt_resp, 1);
        check("p2_resp_dout", resp_dout, 16'hABCD);
        set_knobs(0, 0, 2, 2, 2, 2, 0);
        do_reset(0);
        repeat (2 * N + 8) step();
        check("p3_ref_count", cnt_ref, 2);
        check("p3_debt_end", refresh_debt, 0);
        set_knobs(100, 1, 1, 3, 2, 2, 0);
        do_reset(0);
        repeat (400) step();
        check("p4_max_debt", max_debt, 4);
        check("p4_refresh_seen", cnt_ref > 0, 1);
        set_knobs(60, 0, 0, 5, 2, 7, 1);
        do_reset(0);
        repeat (1500) step();
        check("p5_reads_served", cnt_resp > 0, 1);
        set_knobs(0, 0, 1, 1, 2, 2, 0);
        do_reset(0);
        stuck = 1;
        repeat (9 * N + 4) step();
        check("p6_debt_sat", refresh_debt, MAXD);
        stuck = 0;
        repeat (40) step();
        check("p6_max_debt", max_debt, MAXD);
        check("p6_overflow_sticky", debt_overflow, 1);
        req_rd = 1'b1; req_addr = 26'h5; req_din = 16'h0;
        set_knobs(0, 0, 8, 8, 7, 7, 0);
        do_reset(1);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            found = m_busy && m_op == 0 && k - 1 >= m_start + 3 && !m_got;
        end
        check("p7_reached_rd_wait", found, 1);
        reset = 1'b1;
        #1 check_reset_outputs();
        do_reset(0);
        repeat (30) step();
        check("p7_no_resp", cnt_resp, 0);
        check("p7_debt", refresh_debt, m_debt);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
